// File: rtl/ddr2_bridge_pkg.sv
// Shared types and constants for the line-cache to MIG-7 native interface bridge.
package ddr2_bridge_pkg;

  localparam int unsigned LINE_W = 128;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef struct packed {
    logic              rd;
    logic [22:0]       line;
    logic [LINE_W-1:0] data;
  } req_t;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } state_t;

endpackage

// File: rtl/ddr2_mig_bridge_fifo.sv
// Synchronous single-clock FIFO; a push into a full FIFO is dropped even if a pop happens the same cycle.
module sync_fifo
  import ddr2_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/ddr2_mig_bridge.sv
// Bridges single-cycle cache line requests onto the MIG-7 native app_* interface, in order.
module ddr2_mig_bridge
  import ddr2_bridge_pkg::*;
#(
  parameter int unsigned REQ_DEPTH  = 4,
  parameter int unsigned MAX_RD_OUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ddr2_enable,
  input  logic                ddr2_read,
  input  logic [26:0]         ddr2_addr,
  input  logic [LINE_W-1:0]   to_ddr2_data,
  output logic [LINE_W-1:0]   ddr2_data,
  output logic                ddr2_available,
  input  logic                init_calib_complete,
  output logic [26:0]         app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [LINE_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [15:0]         app_wdf_mask,
  input  logic                app_wdf_rdy,
  input  logic [LINE_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  input  logic                app_rd_data_end,
  output logic                req_overflow,
  output logic                rsp_error,
  output logic                busy
);

  localparam int unsigned RD_W = $clog2(MAX_RD_OUT + 1);

  req_t                    push_req;
  req_t                    head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(REQ_DEPTH):0] fifo_count;
  logic                    pop;
  logic                    rd_inc;
  logic                    rd_dec;
  logic [RD_W-1:0]         rd_out;

  state_t state, state_n;
  logic   cmd_done, cmd_done_n;
  logic   wdf_done, wdf_done_n;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, app_rd_data_end, ddr2_addr[3:0], fifo_count};

  assign push_req.rd   = ddr2_read;
  assign push_req.line = ddr2_addr[26:4];
  assign push_req.data = to_ddr2_data;

  sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ddr2_enable),
    .pop   (pop),
    .din   (push_req),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd_done <= 1'b0;
      wdf_done <= 1'b0;
    end else begin
      state    <= state_n;
      cmd_done <= cmd_done_n;
      wdf_done <= wdf_done_n;
    end
  end

  // Write command and data beat are accepted independently; the entry retires once both have gone.
  always_comb begin
    state_n    = state;
    cmd_done_n = cmd_done;
    wdf_done_n = wdf_done;
    pop        = 1'b0;
    rd_inc     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty && init_calib_complete &&
            (!head.rd || (rd_out < RD_W'(MAX_RD_OUT))))
          state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (head.rd) begin
          if (app_rdy) begin
            pop     = 1'b1;
            rd_inc  = 1'b1;
            state_n = ST_IDLE;
          end
        end else if ((cmd_done || app_rdy) && (wdf_done || app_wdf_rdy)) begin
          pop        = 1'b1;
          cmd_done_n = 1'b0;
          wdf_done_n = 1'b0;
          state_n    = ST_IDLE;
        end else begin
          cmd_done_n = cmd_done || app_rdy;
          wdf_done_n = wdf_done || app_wdf_rdy;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_cmd      = APP_CMD_WR;
    app_addr     = '0;
    app_wdf_data = '0;
    if (state == ST_ISSUE) begin
      app_addr = {1'b0, head.line, 3'b000};
      if (head.rd) begin
        app_cmd = APP_CMD_RD;
        app_en  = 1'b1;
      end else begin
        app_en       = !cmd_done;
        app_wdf_wren = !wdf_done;
        app_wdf_data = head.data;
      end
    end
  end

  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;

  assign rd_dec = app_rd_data_valid && (rd_out != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_out         <= '0;
      ddr2_data      <= '0;
      ddr2_available <= 1'b0;
      req_overflow   <= 1'b0;
      rsp_error      <= 1'b0;
    end else begin
      if (rd_inc && !rd_dec)      rd_out <= rd_out + RD_W'(1);
      else if (rd_dec && !rd_inc) rd_out <= rd_out - RD_W'(1);
      ddr2_available <= rd_dec;
      if (rd_dec) ddr2_data <= app_rd_data;
      if (ddr2_enable && fifo_full) req_overflow <= 1'b1;
      if (app_rd_data_valid && (rd_out == '0)) rsp_error <= 1'b1;
    end
  end

  assign busy = !fifo_empty || (rd_out != '0);

endmodule

// File: tb/tb_ddr2_mig_bridge.sv
// Self-checking bench: MIG-side model with scoreboard queues for commands, write beats and read returns.
module tb_ddr2_mig_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         ddr2_enable;
  logic         ddr2_read;
  logic [26:0]  ddr2_addr;
  logic [127:0] to_ddr2_data;
  logic [127:0] ddr2_data;
  logic         ddr2_available;
  logic         init_calib_complete;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         req_overflow;
  logic         rsp_error;
  logic         busy;

  always #5 clk = ~clk;

  ddr2_mig_bridge #(.REQ_DEPTH(4), .MAX_RD_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .ddr2_enable(ddr2_enable), .ddr2_read(ddr2_read), .ddr2_addr(ddr2_addr),
    .to_ddr2_data(to_ddr2_data), .ddr2_data(ddr2_data), .ddr2_available(ddr2_available),
    .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .req_overflow(req_overflow), .rsp_error(rsp_error), .busy(busy)
  );

  typedef struct { logic [2:0] cmd; logic [26:0] addr; } cmd_t;
  typedef struct { int due; logic [127:0] d; } ret_t;
  typedef struct {
    logic         rd;
    logic [26:0]  addr;
    logic [127:0] wdata;
    logic [26:0]  exp_app_addr;
  } vec_t;

  cmd_t         exp_cmd[$];
  logic [127:0] exp_wdf[$];
  logic [127:0] exp_rd[$];
  ret_t         ret_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int ret_delay = 3;
  int cmd_accs = 0, wdf_accs = 0, avail_cnt = 0, en_cycles = 0;
  int mig_out = 0, max_out = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [26:0] a);
    return {16{8'hA5}} ^ {101'b0, a};
  endfunction

  // MIG model: scoreboard compares at the negedge before the accepting posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (app_en) en_cycles++;
      if (app_en && app_rdy) begin
        cmd_t e;
        ret_t r;
        cmd_accs++;
        if (exp_cmd.size() == 0) chk("unexpected_cmd", {125'b0, app_cmd}, 128'h0 - 1);
        else begin
          e = exp_cmd.pop_front();
          chk("app_cmd", {125'b0, app_cmd}, {125'b0, e.cmd});
          chk("app_addr", {101'b0, app_addr}, {101'b0, e.addr});
        end
        if (app_cmd == 3'b001) begin
          r.due = cyc + ret_delay;
          r.d   = pat(app_addr);
          ret_q.push_back(r);
          mig_out++;
          if (mig_out > max_out) max_out = mig_out;
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        wdf_accs++;
        chk("wdf_end_mask", {111'b0, app_wdf_end, app_wdf_mask}, {111'b0, 1'b1, 16'h0});
        if (exp_wdf.size() == 0) chk("unexpected_wdf", app_wdf_data, 128'h0 - 1);
        else chk("wdf_data", app_wdf_data, exp_wdf.pop_front());
      end
      if (ddr2_available) begin
        avail_cnt++;
        if (exp_rd.size() == 0) chk("unexpected_avail", ddr2_data, 128'h0 - 1);
        else chk("rd_data", ddr2_data, exp_rd.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    app_rd_data_valid = 1'b0;
    app_rd_data       = '0;
    if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
      ret_t r;
      r = ret_q.pop_front();
      app_rd_data_valid = 1'b1;
      app_rd_data       = r.d;
      if (mig_out > 0) mig_out--;
    end
  end

  task automatic req(input logic rd, input logic [26:0] a, input logic [127:0] d);
    ddr2_enable  = 1'b1;
    ddr2_read    = rd;
    ddr2_addr    = a;
    to_ddr2_data = d;
    @(posedge clk); #1;
    ddr2_enable  = 1'b0;
  endtask

  task automatic expect_req(input logic rd, input logic [26:0] app_a, input logic [127:0] d);
    cmd_t e;
    e.cmd  = rd ? 3'b001 : 3'b000;
    e.addr = app_a;
    exp_cmd.push_back(e);
    if (rd) exp_rd.push_back(pat(app_a));
    else    exp_wdf.push_back(d);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (n < 300 && (busy || exp_cmd.size() != 0 || exp_wdf.size() != 0 ||
                       exp_rd.size() != 0 || ret_q.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, 128'(n >= 300), 128'h0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b_acc, b_wdf, b_av, b_en, n;

    vecs[0] = '{1'b1, 27'h0001230, 128'h0,                                   27'h0000918};
    vecs[1] = '{1'b0, 27'h00044F0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 27'h0002278};
    vecs[2] = '{1'b1, 27'h0100000, 128'h0,                                   27'h0080000};
    vecs[3] = '{1'b0, 27'h7FFFFF0, {4{32'hDEAD_BEEF}},                        27'h3FFFFF8};
    vecs[4] = '{1'b1, 27'h000000F, 128'h0,                                   27'h0000000};
    vecs[5] = '{1'b0, 27'h5555555, {8{16'h5A3C}},                             27'h2AAAAA8};

    rst = 1'b1; ddr2_enable = 1'b0; ddr2_read = 1'b0; ddr2_addr = '0; to_ddr2_data = '0;
    init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_end = 1'b0;
    app_rd_data_valid = 1'b0; app_rd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {119'b0, ddr2_available, app_en, app_wdf_wren, req_overflow, rsp_error, busy, 3'b0},
        128'h0);
    chk("reset_ddr2_data", ddr2_data, 128'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Test 1: single read, 10-cycle return, app_en timing after the push edge
    ret_delay = 10;
    b_av = avail_cnt;
    expect_req(1'b1, 27'h0000918, '0);
    req(1'b1, 27'h0001230, '0);
    @(negedge clk);
    chk("t1_no_en_in_push_cycle", {127'b0, app_en}, 128'h0);
    @(negedge clk);
    chk("t1_en_next_cycle", {127'b0, app_en}, 128'h1);
    wait_idle("t1");
    chk("t1_one_avail", 128'(avail_cnt - b_av), 128'h1);
    chk("t1_busy_clear", {127'b0, busy}, 128'h0);
    ret_delay = 3;

    // Table: each vector issued in isolation
    for (int i = 0; i < 6; i++) begin
      expect_req(vecs[i].rd, vecs[i].exp_app_addr, vecs[i].wdata);
      req(vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      wait_idle("vec");
    end

    // Test 2: write-back followed by refill on consecutive cycles
    b_av = avail_cnt;
    expect_req(1'b0, 27'h0002278, {4{32'hCAFE_F00D}});
    expect_req(1'b1, 27'h0080000, '0);
    req(1'b0, 27'h00044F0, {4{32'hCAFE_F00D}});
    req(1'b1, 27'h0100000, '0);
    wait_idle("t2");
    chk("t2_one_avail", 128'(avail_cnt - b_av), 128'h1);

    // Test 3: data channel stalled 5 cycles while the command goes at once
    b_acc = cmd_accs; b_wdf = wdf_accs;
    app_wdf_rdy = 1'b0;
    expect_req(1'b0, 27'h0000048, {2{64'h1111_2222_3333_4444}});
    req(1'b0, 27'h0000090, {2{64'h1111_2222_3333_4444}});
    n = 0;
    @(negedge clk);
    while (!app_wdf_wren && n < 20) begin @(negedge clk); n++; end
    chk("t3_wren_seen", 128'(n >= 20), 128'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_wren_held", {126'b0, app_wdf_wren, busy}, 128'h3);
      chk("t3_cmd_not_repeated", {127'b0, app_en}, 128'h0);
      @(posedge clk); #1;
    end
    app_wdf_rdy = 1'b1;
    wait_idle("t3");
    chk("t3_cmd_accs", 128'(cmd_accs - b_acc), 128'h1);
    chk("t3_wdf_accs", 128'(wdf_accs - b_wdf), 128'h1);

    // Test 4: overflow while the MIG is not ready
    app_rdy = 1'b0;
    expect_req(1'b0, 27'h0000080, {4{32'h0000_0100}});
    expect_req(1'b1, 27'h0000100, '0);
    expect_req(1'b0, 27'h0000180, {4{32'h0000_0300}});
    expect_req(1'b1, 27'h0000200, '0);
    chk("t4_no_overflow_yet", {127'b0, req_overflow}, 128'h0);
    req(1'b0, 27'h0000100, {4{32'h0000_0100}});
    req(1'b1, 27'h0000200, '0);
    req(1'b0, 27'h0000300, {4{32'h0000_0300}});
    req(1'b1, 27'h0000400, '0);
    req(1'b1, 27'h0000500, '0);
    @(negedge clk);
    chk("t4_overflow", {127'b0, req_overflow}, 128'h1);
    @(posedge clk); #1;
    app_rdy = 1'b1;
    wait_idle("t4");
    chk("t4_overflow_sticky", {127'b0, req_overflow}, 128'h1);
    do_reset();
    @(negedge clk);
    chk("t4_flags_reset", {126'b0, req_overflow, rsp_error}, 128'h0);
    @(posedge clk); #1;

    // Outstanding-read limit: five reads, long return latency
    ret_delay = 30; max_out = 0;
    for (int i = 0; i < 5; i++) expect_req(1'b1, 27'(32'h400 + i * 8), '0);
    for (int i = 0; i < 5; i++) req(1'b1, 27'(32'h800 + i * 16), '0);
    wait_idle("rdmax");
    chk("rd_out_cap", 128'(max_out), 128'h4);
    ret_delay = 3;

    // Test 5: calibration gate
    init_calib_complete = 1'b0;
    b_en = en_cycles;
    expect_req(1'b1, 27'h0000A00, '0);
    expect_req(1'b0, 27'h0000A08, {4{32'h5555_AAAA}});
    req(1'b1, 27'h0001400, '0);
    req(1'b0, 27'h0001410, {4{32'h5555_AAAA}});
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_en_uncalibrated", 128'(en_cycles - b_en), 128'h0);
    init_calib_complete = 1'b1;
    @(negedge clk);
    chk("t5_en_not_same_cycle", {127'b0, app_en}, 128'h0);
    @(negedge clk);
    chk("t5_en_one_cycle_later", {124'b0, app_en, app_cmd}, 128'h9);
    wait_idle("t5");

    // Test 6: reset with a read in flight, late return must be flagged and dropped
    ret_delay = 8;
    b_acc = cmd_accs;
    begin
      cmd_t e;
      e.cmd = 3'b001; e.addr = 27'h0000C00;
      exp_cmd.push_back(e);
    end
    req(1'b1, 27'h0001800, '0);
    n = 0;
    while (cmd_accs == b_acc && n < 20) begin @(negedge clk); n++; end
    chk("t6_read_accepted", 128'(n >= 20), 128'h0);
    @(posedge clk); #1;
    b_av = avail_cnt;
    do_reset();
    n = 0;
    while (ret_q.size() != 0 && n < 40) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_no_avail", 128'(avail_cnt - b_av), 128'h0);
    chk("t6_rsp_error_busy", {126'b0, rsp_error, busy}, 128'h2);
    chk("t6_avail_low", {127'b0, ddr2_available}, 128'h0);

    chk("end_queues_empty", 128'(exp_cmd.size() + exp_wdf.size() + exp_rd.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
